// File: rtl/scratch_mem_arbiter_if.sv
// Bus bundle for scratch_mem_arbiter: two requester ports plus the shared BRAM port.
// slave = arbiter side, master = requesters and BRAM side.
interface scratch_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              r0_req;
    logic [3:0]        r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [31:0]       r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [31:0]       r0_rdata;

    logic              r1_req;
    logic [3:0]        r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [31:0]       r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [31:0]       r1_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// Two-requester arbiter for the data scratch BRAM port: fixed priority to r0 with an r1
// starvation guard. Optional SCRATCH_ARB_STATS_EN adds contention/forced-grant counters.
module scratch_mem_arbiter #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned MAX_CONSEC  = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    scratch_mem_arbiter_if.slave   bus
`ifdef SCRATCH_ARB_STATS_EN
    ,
    output logic [31:0]            stat_contend,
    output logic [31:0]            stat_r1_forced
`endif
);

    localparam int unsigned Depth  = MEM_LATENCY + 1;
    localparam logic [3:0]  MaxCnt = 4'(MAX_CONSEC);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              both_req, force_r1, gnt0, gnt1, any_gnt, issue_rd;
    logic [3:0]        win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;

    logic              mem_en_q;
    logic [3:0]        mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_din_q;
    logic [Depth-1:0]  tag_valid_q, tag_owner_q;
    logic [31:0]       r0_rdata_q, r1_rdata_q;
    logic              ret0, ret1;

    assign both_req = bus.r0_req & bus.r1_req;
    assign force_r1 = both_req & (starve_cnt_q == MaxCnt);
    // Grants are masked while reset is asserted so nothing is accepted during reset.
    assign gnt0     = sys_rst_n & bus.r0_req & ~force_r1;
    assign gnt1     = sys_rst_n & bus.r1_req & (~bus.r0_req | force_r1);
    assign any_gnt  = gnt0 | gnt1;

    always_comb begin
        win_we    = bus.r0_we;
        win_addr  = bus.r0_addr;
        win_wdata = bus.r0_wdata;
        if (gnt1) begin
            win_we    = bus.r1_we;
            win_addr  = bus.r1_addr;
            win_wdata = bus.r1_wdata;
        end
    end

    assign issue_rd = any_gnt & (win_we == 4'b0000);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt1 || !bus.r1_req) begin
            starve_cnt_d = 4'd0;
        end else if (both_req && starve_cnt_q < MaxCnt) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            starve_cnt_q <= 4'd0;
            tag_valid_q  <= '0;
            tag_owner_q  <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            mem_en_q <= any_gnt;
            if (any_gnt) begin
                mem_we_q   <= win_we;
                mem_addr_q <= win_addr;
                mem_din_q  <= win_wdata;
            end else begin
                mem_we_q   <= 4'b0000;
            end
            starve_cnt_q <= starve_cnt_d;
            // Tag reaches the last stage in the same cycle the BRAM presents its data.
            tag_valid_q  <= {tag_valid_q[Depth-2:0], issue_rd};
            tag_owner_q  <= {tag_owner_q[Depth-2:0], gnt1};
            r0_rdata_q   <= bus.r0_rdata;
            r1_rdata_q   <= bus.r1_rdata;
        end
    end

    assign ret0 = tag_valid_q[Depth-1] & ~tag_owner_q[Depth-1];
    assign ret1 = tag_valid_q[Depth-1] &  tag_owner_q[Depth-1];

    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.r0_rvalid = ret0;
    assign bus.r1_rvalid = ret1;
    assign bus.r0_rdata  = ret0 ? bus.mem_dout : r0_rdata_q;
    assign bus.r1_rdata  = ret1 ? bus.mem_dout : r1_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;

`ifdef SCRATCH_ARB_STATS_EN
    logic [31:0] contend_q, forced_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            contend_q <= '0;
            forced_q  <= '0;
        end else begin
            if (both_req && contend_q != 32'hFFFF_FFFF) begin
                contend_q <= contend_q + 32'd1;
            end
            if (force_r1 && forced_q != 32'hFFFF_FFFF) begin
                forced_q <= forced_q + 32'd1;
            end
        end
    end

    assign stat_contend   = contend_q;
    assign stat_r1_forced = forced_q;
`endif

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Scoreboard bench for scratch_mem_arbiter: two instances (MEM_LATENCY 1 and 2) share the
// requester stimulus; each has its own BRAM model. Checks stats when SCRATCH_ARB_STATS_EN.
module tb_scratch_mem_arbiter;

    localparam int unsigned AW = 30;

    typedef struct {
        int          dut;
        int          owner;
        logic [31:0] data;
        int          due;
    } ret_t;

    typedef struct {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   din;
        int            due;
    } iss_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic preload = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    logic          r0_req, r1_req;
    logic [3:0]    r0_we, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [31:0]   r0_wdata, r1_wdata;

    ret_t        rq[$];
    iss_t        iq[$];
    logic        glog[$];
    logic [31:0] last [2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scratch_mem_arbiter_if #(.ADDR_W(AW)) bus1 ();
    scratch_mem_arbiter_if #(.ADDR_W(AW)) bus2 ();

    assign bus1.r0_req = r0_req;   assign bus2.r0_req = r0_req;
    assign bus1.r0_we = r0_we;     assign bus2.r0_we = r0_we;
    assign bus1.r0_addr = r0_addr; assign bus2.r0_addr = r0_addr;
    assign bus1.r0_wdata = r0_wdata; assign bus2.r0_wdata = r0_wdata;
    assign bus1.r1_req = r1_req;   assign bus2.r1_req = r1_req;
    assign bus1.r1_we = r1_we;     assign bus2.r1_we = r1_we;
    assign bus1.r1_addr = r1_addr; assign bus2.r1_addr = r1_addr;
    assign bus1.r1_wdata = r1_wdata; assign bus2.r1_wdata = r1_wdata;

`ifdef SCRATCH_ARB_STATS_EN
    logic [31:0] st_c1, st_f1, st_c2, st_f2;
`endif

    scratch_mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(1), .MAX_CONSEC(4)) u_dut1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus1)
`ifdef SCRATCH_ARB_STATS_EN
        , .stat_contend(st_c1), .stat_r1_forced(st_f1)
`endif
    );

    scratch_mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(2), .MAX_CONSEC(4)) u_dut2 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus2)
`ifdef SCRATCH_ARB_STATS_EN
        , .stat_contend(st_c2), .stat_r1_forced(st_f2)
`endif
    );

    // Read-first BRAM models, latency 1 and 2.
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [31:0] p1, p2a, p2b;

    assign bus1.mem_dout = p1;
    assign bus2.mem_dout = p2b;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (we[b]) m[8*b +: 8] = wd[8*b +: 8];
        return m;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 32'h0;
                mem2[i] <= 32'h0;
            end
            mem1[8'h04] <= 32'h1111_0004; mem2[8'h04] <= 32'h1111_0004;
            mem1[8'h08] <= 32'h2222_0008; mem2[8'h08] <= 32'h2222_0008;
            mem1[8'h10] <= 32'hDEAD_BEEF; mem2[8'h10] <= 32'hDEAD_BEEF;
            mem1[8'h20] <= 32'hFFFF_0000; mem2[8'h20] <= 32'hFFFF_0000;
        end else begin
            if (bus1.mem_en) begin
                p1 <= mem1[bus1.mem_addr[7:0]];
                if (bus1.mem_we != 4'b0000)
                    mem1[bus1.mem_addr[7:0]] <= merge(mem1[bus1.mem_addr[7:0]], bus1.mem_din,
                                                      bus1.mem_we);
            end
            if (bus2.mem_en) begin
                p2a <= mem2[bus2.mem_addr[7:0]];
                if (bus2.mem_we != 4'b0000)
                    mem2[bus2.mem_addr[7:0]] <= merge(mem2[bus2.mem_addr[7:0]], bus2.mem_din,
                                                      bus2.mem_we);
            end
            p2b <= p2a;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event, want none/other (cycle %0d)", name, cyc);
    endtask

    task automatic set_req(input int r, input logic req, input logic [3:0] we,
                           input logic [AW-1:0] addr, input logic [31:0] wd);
        if (r == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end
    endtask

    // Present one request, wait for its grant and log the expected BRAM issue and return.
    task automatic drive(input int r, input logic [3:0] we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp);
        int   n = 0;
        bit   got = 1'b0;
        iss_t s;
        ret_t e;
        set_req(r, 1'b1, we, addr, wd);
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (r == 0 ? bus1.r0_gnt : bus1.r1_gnt) begin
                got = 1'b1;
                s.we = we; s.addr = addr; s.din = wd; s.due = cyc + 1;
                iq.push_back(s);
                if (we == 4'b0000) begin
                    e.owner = r; e.data = exp;
                    e.dut = 0; e.due = cyc + 2; rq.push_back(e);
                    e.dut = 1; e.due = cyc + 3; rq.push_back(e);
                end
            end
        end
        if (!got) fail("gnt_timeout");
        @(posedge clk);
        #1;
        set_req(r, 1'b0, we, addr, wd);
    endtask

    task automatic mon_ret(input int d, input logic v0, input logic v1,
                           input logic [31:0] d0, input logic [31:0] d1);
        int   idx = -1;
        ret_t e;
        for (int i = 0; i < rq.size(); i++) begin
            if (rq[i].dut == d) begin
                idx = i;
                break;
            end
        end
        if (v0 || v1) begin
            if (v0 && v1) fail("rvalid_both");
            if (idx < 0) begin
                fail("ret_unexpected");
            end else begin
                e = rq[idx];
                rq.delete(idx);
                chk("ret_owner", {63'b0, v1}, e.owner);
                chk("ret_cycle", cyc, e.due);
                chk("ret_data", v1 ? d1 : d0, e.data);
                last[d][e.owner] = e.data;
            end
        end else if (idx >= 0 && rq[idx].due <= cyc) begin
            fail("ret_missing");
            rq.delete(idx);
        end
        if (!v0) chk("r0_rdata_hold", d0, last[d][0]);
        if (!v1) chk("r1_rdata_hold", d1, last[d][1]);
    endtask

    task automatic mon_iss();
        iss_t s;
        if (bus1.mem_en || bus2.mem_en) begin
            if (iq.size() == 0) begin
                fail("mem_en_unexpected");
            end else begin
                s = iq.pop_front();
                chk("mem_en_cycle", cyc, s.due);
                chk("mem_en_both", {bus1.mem_en, bus2.mem_en}, 2'b11);
                chk("mem_we", bus1.mem_we, s.we);
                chk("mem_addr", bus1.mem_addr, s.addr);
                chk("mem_din", bus1.mem_din, s.din);
                chk("mem2_we_addr", {bus2.mem_we, bus2.mem_addr}, {s.we, s.addr});
            end
        end else begin
            chk("mem_we_idle", {bus1.mem_we, bus2.mem_we}, 8'h00);
            if (iq.size() != 0 && iq[0].due <= cyc) begin
                fail("mem_en_missing");
                void'(iq.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !preload) begin
            if (bus1.r0_gnt && bus1.r1_gnt) fail("gnt_both");
            else if (bus1.r0_gnt || bus1.r1_gnt) glog.push_back(bus1.r1_gnt);
            mon_iss();
            mon_ret(0, bus1.r0_rvalid, bus1.r1_rvalid, bus1.r0_rdata, bus1.r1_rdata);
            mon_ret(1, bus2.r0_rvalid, bus2.r1_rvalid, bus2.r0_rdata, bus2.r1_rdata);
        end
    end

    task automatic chk_glog(input string name, input logic [15:0] seq, input int n);
        chk({name, "_len"}, glog.size(), n);
        for (int i = 0; i < n; i++) if (i < glog.size()) chk(name, glog[i], seq[i]);
    endtask

    task automatic clear_sb();
        rq.delete();
        iq.delete();
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) last[d][r] = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_sb();
        set_req(0, 1'b1, 4'b0000, 'h10, 32'h0);
        set_req(1, 1'b1, 4'b0000, 'h08, 32'h0);
        @(posedge clk);
        #1 preload = 1'b0;

        // Reset held with both requesting: every output quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", {bus1.r0_gnt, bus1.r1_gnt, bus2.r0_gnt, bus2.r1_gnt}, 4'h0);
            chk("rst_mem_en", {bus1.mem_en, bus2.mem_en}, 2'b00);
            chk("rst_mem_we", bus1.mem_we, 4'h0);
            chk("rst_mem_addr", bus1.mem_addr, 0);
            chk("rst_mem_din", bus1.mem_din, 32'h0);
            chk("rst_rvalid", {bus1.r0_rvalid, bus1.r1_rvalid, bus2.r0_rvalid, bus2.r1_rvalid},
                4'h0);
            chk("rst_rdata", {bus1.r0_rdata, bus1.r1_rdata}, 64'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        glog.delete();
        fork
            drive(0, 4'b0000, 'h10, 32'h0, 32'hDEAD_BEEF);
            drive(1, 4'b0000, 'h08, 32'h0, 32'h2222_0008);
        join
        chk_glog("release_seq", 16'h0002, 2);

        drive(0, 4'b0000, 'h10, 32'h0, 32'hDEAD_BEEF);

        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b0000, 'h04, 32'h0, 32'h1111_0004);
            drive(1, 4'b0000, 'h08, 32'h0, 32'h2222_0008);
        end

        drive(1, 4'b0011, 'h20, 32'h0000_ABCD, 32'h0);
        drive(1, 4'b0000, 'h20, 32'h0, 32'hFFFF_ABCD);

        // r1 loses one contested cycle, then reset lands on r0's in-flight read.
        set_req(1, 1'b1, 4'b0000, 'h08, 32'h0);
        drive(0, 4'b0000, 'h10, 32'h0, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        clear_sb();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        glog.delete();
        fork
            begin
                repeat (9) drive(0, 4'b0000, 'h10, 32'h0, 32'hDEAD_BEEF);
            end
            begin
                repeat (2) drive(1, 4'b0000, 'h08, 32'h0, 32'h2222_0008);
            end
        join
        chk_glog("starve_seq", 16'h0210, 11);
`ifdef SCRATCH_ARB_STATS_EN
        chk("stat_r1_forced", st_f1, 32'd2);
        chk("stat_contend", st_c1, 32'd10);
        chk("stat2", {st_f2, st_c2}, {32'd2, 32'd10});
`endif

        repeat (6) @(negedge clk);
        chk("drain_ret", rq.size(), 0);
        chk("drain_iss", iq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
